dbus_ctrl: RTL

DBUS_CTRL -- requirements
Module: dbus_ctrl

---
 rtl/dbus_ctrl_if.sv | 28 ++
 rtl/dbus_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dbus_ctrl_if.sv
// Memory-stage request/response and external data-bus control signals for dbus_ctrl.
// DDT is bidirectional and stays a plain inout port on the controller.
interface dbus_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  inst_size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        error;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;

  modport slave (
    input  mem_read, mem_write, inst_size, load_unsigned, address, write_data, ACKD_n,
    output read_data, stall, error, DAD, MREQ, WRITE, SIZE
  );

  modport master (
    output mem_read, mem_write, inst_size, load_unsigned, address, write_data, ACKD_n,
    input  read_data, stall, error, DAD, MREQ, WRITE, SIZE
  );
endinterface

// File: rtl/dbus_ctrl.sv
// Data-bus controller: turns memory-stage loads/stores into IDLE/ACCESS/DONE bus cycles.
// Define DBUS_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT_CYCLES cycles.
module dbus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  dbus_ctrl_if.slave   bus,
  inout  wire  [31:0]  DDT
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_dad, r_wdata, r_rdata;
  logic [1:0]  r_size;
  logic        r_write, r_uns, r_error;

  logic        w_req, w_aligned, w_start, w_ack, w_timeout, w_error_d;
  logic [31:0] w_wdata_rep, w_load, w_rdata_d;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_req   = bus.mem_read | bus.mem_write;
  assign w_start = (r_state == StIdle) & w_req & w_aligned;
  assign w_ack   = ~bus.ACKD_n;

  always_comb begin
    w_aligned = 1'b0;
    unique case (bus.inst_size)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~bus.address[0];
      2'b10:   w_aligned = (bus.address[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  // Narrow stores are replicated across all lanes; the memory picks the lane from DAD/SIZE.
  always_comb begin
    w_wdata_rep = bus.write_data;
    unique case (bus.inst_size)
      2'b00:   w_wdata_rep = {4{bus.write_data[7:0]}};
      2'b01:   w_wdata_rep = {2{bus.write_data[15:0]}};
      default: w_wdata_rep = bus.write_data;
    endcase
  end

  always_comb begin
    w_byte = DDT[{r_dad[1:0], 3'b000} +: 8];
    w_half = r_dad[1] ? DDT[31:16] : DDT[15:0];
    w_load = DDT;
    unique case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = DDT;
    endcase
  end

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] r_cnt;

  assign w_timeout = (r_state == StAccess) && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state == StAccess) && !w_ack && !w_timeout) begin
      r_cnt <= r_cnt + CntW'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    w_state_d = r_state;
    w_error_d = 1'b0;
    w_rdata_d = r_rdata;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_d = StAccess;
        w_error_d = w_req & ~w_aligned;
      end
      StAccess: begin
        if (w_ack) begin
          w_state_d = StDone;
          if (!r_write) w_rdata_d = w_load;
        end else if (w_timeout) begin
          w_state_d = StDone;
          w_error_d = 1'b1;
          w_rdata_d = '0;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_dad   <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_error <= w_error_d;
      r_rdata <= w_rdata_d;
      // Request fields are captured once; upstream changes during ACCESS are ignored.
      if (w_start) begin
        r_dad   <= bus.address;
        r_size  <= bus.inst_size;
        r_write <= bus.mem_write;
        r_uns   <= bus.load_unsigned;
        r_wdata <= w_wdata_rep;
      end
    end
  end

  assign bus.MREQ      = (r_state == StAccess);
  assign bus.stall     = w_start | (r_state == StAccess);
  assign bus.error     = r_error;
  assign bus.read_data = r_rdata;
  assign bus.DAD       = r_dad;
  assign bus.SIZE      = r_size;
  assign bus.WRITE     = r_write;
  assign DDT           = ((r_state == StAccess) && r_write) ? r_wdata : 32'bz;

endmodule
